// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM steering the program_counter through idle, load, run and done.
// Ports: clk, rst_n; launch/launch_addr start a program; pc_value plus decode
//   (stall, is_branch, branch_cond, branch_target, is_halt) drive the run phase;
//   pc_start/pc_start_address/pc_branch/pc_taken/pc_target feed the program_counter;
//   fetch_valid, busy, done, timeout, overrun, instr_count report status.
module pc_sequencer #(
    parameter int INSTR_W    = 9,
    parameter int SIZE       = 256,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               launch,
    input  logic [INSTR_W-1:0] launch_addr,
    input  logic [INSTR_W-1:0] pc_value,
    input  logic               stall,
    input  logic               is_branch,
    input  logic               branch_cond,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               is_halt,
    output logic               pc_start,
    output logic [INSTR_W-1:0] pc_start_address,
    output logic               pc_branch,
    output logic               pc_taken,
    output logic [INSTR_W-1:0] pc_target,
    output logic               fetch_valid,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               overrun,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [INSTR_W-1:0] LAST_ADDR = INSTR_W'(SIZE - 1);
    localparam logic [CNT_W-1:0]   WD_LAST   = CNT_W'(MAX_CYCLES - 1);

    state_t             state;
    logic [INSTR_W-1:0] addr_reg;
    logic [CNT_W-1:0]   cycle_cnt;

    logic run;
    logic fire;
    logic taken_br;
    logic halt_exit;
    logic ovr_exit;
    logic wd_exit;
    logic freeze;

    always_comb begin
        run       = (state == RUN);
        fire      = run && !stall;
        taken_br  = is_branch && branch_cond;
        halt_exit = fire && is_halt;
        // Falling off the last address ends the run unless control
        // leaves via halt or a taken branch.
        ovr_exit  = fire && !is_halt && !taken_br && (pc_value == LAST_ADDR);
        wd_exit   = run && (cycle_cnt == WD_LAST) && !halt_exit && !ovr_exit;
        // The PC has no hold input: freezing is a taken branch to itself.
        freeze    = run && (stall || is_halt || ovr_exit || wd_exit);
    end

    always_comb begin
        pc_start         = !run;
        pc_start_address = addr_reg;
        pc_branch        = 1'b0;
        pc_taken         = 1'b0;
        pc_target        = pc_value;
        if (freeze) begin
            pc_branch = 1'b1;
            pc_taken  = 1'b1;
        end else if (run && is_branch) begin
            pc_branch = 1'b1;
            pc_taken  = branch_cond;
            pc_target = branch_target;
        end
    end

    // A watchdog exit behaves as a stall, so that instruction does not retire.
    assign fetch_valid = fire && !wd_exit;
    assign busy        = (state == LOAD) || (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_reg    <= '0;
            instr_count <= '0;
            cycle_cnt   <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        addr_reg    <= launch_addr;
                        instr_count <= '0;
                        cycle_cnt   <= '0;
                        timeout     <= 1'b0;
                        overrun     <= 1'b0;
                        state       <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (fetch_valid && (instr_count != '1)) begin
                        instr_count <= instr_count + CNT_W'(1);
                    end
                    if (ovr_exit) begin
                        overrun <= 1'b1;
                    end
                    if (wd_exit) begin
                        timeout <= 1'b1;
                    end
                    if (halt_exit || ovr_exit || wd_exit) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a program_counter model.
// Ports: none; drives two instances (default watchdog and MAX_CYCLES=8).
module tb_pc_sequencer;

    localparam int W = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main instance
    logic         launch = 1'b0;
    logic [W-1:0] launch_addr = '0;
    logic [W-1:0] pc;
    logic         stall = 1'b0;
    logic         is_branch, branch_cond, is_halt;
    logic [W-1:0] branch_target;
    logic         halt_en = 1'b0;
    logic [W-1:0] halt_pc = '0;
    logic         br_en = 1'b0;
    logic         br_cond = 1'b0;
    logic [W-1:0] br_pc = '0;
    logic [W-1:0] br_tgt = '0;
    logic         pc_start, pc_branch, pc_taken, fetch_valid;
    logic [W-1:0] pc_start_address, pc_target;
    logic         busy, done, timeout, overrun;
    logic [15:0]  instr_count;

    always_comb begin
        is_halt       = halt_en && (pc == halt_pc);
        is_branch     = br_en && (pc == br_pc);
        branch_cond   = br_cond;
        branch_target = br_tgt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (pc_start) pc <= pc_start_address;
        else if (pc_branch && pc_taken) pc <= pc_target;
        else pc <= pc + 1'b1;
    end

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .launch(launch), .launch_addr(launch_addr),
        .pc_value(pc), .stall(stall),
        .is_branch(is_branch), .branch_cond(branch_cond),
        .branch_target(branch_target), .is_halt(is_halt),
        .pc_start(pc_start), .pc_start_address(pc_start_address),
        .pc_branch(pc_branch), .pc_taken(pc_taken), .pc_target(pc_target),
        .fetch_valid(fetch_valid), .busy(busy), .done(done),
        .timeout(timeout), .overrun(overrun), .instr_count(instr_count)
    );

    // watchdog instance
    logic         w_launch = 1'b0;
    logic [W-1:0] w_launch_addr = '0;
    logic [W-1:0] w_pc;
    logic         w_stall = 1'b0;
    logic         w_is_branch, w_branch_cond, w_is_halt;
    logic [W-1:0] w_branch_target;
    logic         w_loop = 1'b0;
    logic         w_halt_en = 1'b0;
    logic [W-1:0] w_halt_pc = '0;
    logic         w_pc_start, w_pc_branch, w_pc_taken, w_fetch_valid;
    logic [W-1:0] w_pc_start_address, w_pc_target;
    logic         w_busy, w_done, w_timeout, w_overrun;
    logic [15:0]  w_instr_count;

    always_comb begin
        w_is_halt       = w_halt_en && (w_pc == w_halt_pc);
        w_is_branch     = w_loop;
        w_branch_cond   = w_loop;
        w_branch_target = w_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_pc <= '0;
        else if (w_pc_start) w_pc <= w_pc_start_address;
        else if (w_pc_branch && w_pc_taken) w_pc <= w_pc_target;
        else w_pc <= w_pc + 1'b1;
    end

    pc_sequencer #(.MAX_CYCLES(8)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .launch(w_launch), .launch_addr(w_launch_addr),
        .pc_value(w_pc), .stall(w_stall),
        .is_branch(w_is_branch), .branch_cond(w_branch_cond),
        .branch_target(w_branch_target), .is_halt(w_is_halt),
        .pc_start(w_pc_start), .pc_start_address(w_pc_start_address),
        .pc_branch(w_pc_branch), .pc_taken(w_pc_taken), .pc_target(w_pc_target),
        .fetch_valid(w_fetch_valid), .busy(w_busy), .done(w_done),
        .timeout(w_timeout), .overrun(w_overrun), .instr_count(w_instr_count)
    );

    task automatic do_launch(input logic [W-1:0] a);
        @(negedge clk);
        launch = 1'b1;
        launch_addr = a;
        @(negedge clk);
        launch = 1'b0;
        checks++;
        if (busy !== 1'b1 || pc_start !== 1'b1 || pc_start_address !== a
            || instr_count !== 16'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL load: busy=%b start=%b addr=%h cnt=%0d ovr=%b want 1 1 %h 0 0",
                     busy, pc_start, pc_start_address, instr_count, overrun, a);
        end
    endtask

    task automatic w_do_launch(input logic [W-1:0] a);
        @(negedge clk);
        w_launch = 1'b1;
        w_launch_addr = a;
        @(negedge clk);
        w_launch = 1'b0;
        checks++;
        if (w_busy !== 1'b1 || w_timeout !== 1'b0 || w_pc_start_address !== a) begin
            errors++;
            $display("FAIL wd_load: busy=%b tmo=%b addr=%h want 1 0 %h",
                     w_busy, w_timeout, w_pc_start_address, a);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pc_start !== 1'b1
            || pc_start_address !== '0 || fetch_valid !== 1'b0
            || instr_count !== 16'd0 || timeout !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b start=%b addr=%h fv=%b cnt=%0d tmo=%b ovr=%b",
                     busy, done, pc_start, pc_start_address, fetch_valid,
                     instr_count, timeout, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pc !== '0) begin
            errors++;
            $display("FAIL idle: busy=%b done=%b pc=%h want 0 0 000", busy, done, pc);
        end
    endtask

    task automatic test_straight;
        halt_en = 1'b1;
        halt_pc = 9'h014;
        br_en = 1'b0;
        do_launch(9'h010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            // a launch mid-run must be ignored
            launch = (i == 1);
            launch_addr = 9'h0A0;
            checks++;
            if (pc !== W'(16 + i) || fetch_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL straight_run%0d: pc=%h fv=%b busy=%b want %h 1 1",
                         i, pc, fetch_valid, busy, W'(16 + i));
            end
        end
        checks++;
        if (pc_branch !== 1'b1 || pc_taken !== 1'b1 || pc_target !== 9'h014) begin
            errors++;
            $display("FAIL halt_freeze: br=%b tk=%b tgt=%h want 1 1 014",
                     pc_branch, pc_taken, pc_target);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd5 || pc !== 9'h014 || busy !== 1'b0
            || timeout !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL straight_done: done=%b cnt=%0d pc=%h busy=%b tmo=%b ovr=%b want 1 5 014 0 0 0",
                     done, instr_count, pc, busy, timeout, overrun);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pc !== 9'h010 || instr_count !== 16'd5) begin
            errors++;
            $display("FAIL straight_park: done=%b pc=%h cnt=%0d want 0 010 5",
                     done, pc, instr_count);
        end
    endtask

    task automatic test_stall;
        logic sv [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int   pcs [9] = '{0, 1, 2, 2, 2, 2, 3, 4, 5};
        halt_en = 1'b1;
        halt_pc = 9'h005;
        do_launch(9'h000);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            stall = sv[i];
            #1;
            checks++;
            if (pc !== W'(pcs[i]) || fetch_valid !== !sv[i]) begin
                errors++;
                $display("FAIL stall_cyc%0d: pc=%h fv=%b want %h %b",
                         i, pc, fetch_valid, W'(pcs[i]), !sv[i]);
            end
            if (sv[i]) begin
                checks++;
                if (pc_branch !== 1'b1 || pc_taken !== 1'b1 || pc_target !== 9'h002) begin
                    errors++;
                    $display("FAIL stall_ctl%0d: br=%b tk=%b tgt=%h want 1 1 002",
                             i, pc_branch, pc_taken, pc_target);
                end
            end
        end
        @(negedge clk);
        stall = 1'b0;
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd6 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b cnt=%0d tmo=%b want 1 6 0",
                     done, instr_count, timeout);
        end
    endtask

    task automatic test_branch(input logic cond);
        logic [W-1:0] nxt;
        nxt = cond ? 9'h020 : 9'h005;
        halt_en = 1'b1;
        halt_pc = nxt;
        br_en = 1'b1;
        br_pc = 9'h004;
        br_cond = cond;
        br_tgt = 9'h020;
        do_launch(9'h000);
        repeat (5) @(negedge clk);
        checks++;
        if (pc !== 9'h004 || pc_branch !== 1'b1 || pc_taken !== cond
            || pc_target !== 9'h020 || instr_count !== 16'd4) begin
            errors++;
            $display("FAIL branch%0d_ctl: pc=%h br=%b tk=%b tgt=%h cnt=%0d want 004 1 %b 020 4",
                     cond, pc, pc_branch, pc_taken, pc_target, instr_count, cond);
        end
        @(negedge clk);
        checks++;
        if (pc !== nxt || instr_count !== 16'd5) begin
            errors++;
            $display("FAIL branch%0d_next: pc=%h cnt=%0d want %h 5",
                     cond, pc, instr_count, nxt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd6) begin
            errors++;
            $display("FAIL branch%0d_done: done=%b cnt=%0d want 1 6",
                     cond, done, instr_count);
        end
        br_en = 1'b0;
    endtask

    task automatic test_overrun;
        halt_en = 1'b0;
        br_en = 1'b0;
        do_launch(9'h0FD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pc !== W'(253 + i) || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL ovr_run%0d: pc=%h fv=%b want %h 1",
                         i, pc, fetch_valid, W'(253 + i));
            end
        end
        checks++;
        if (pc_branch !== 1'b1 || pc_taken !== 1'b1 || pc_target !== 9'h0FF) begin
            errors++;
            $display("FAIL ovr_freeze: br=%b tk=%b tgt=%h want 1 1 0ff",
                     pc_branch, pc_taken, pc_target);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || overrun !== 1'b1 || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL ovr_done: done=%b ovr=%b cnt=%0d want 1 1 3",
                     done, overrun, instr_count);
        end
        br_en = 1'b1;
        br_pc = 9'h0FF;
        br_cond = 1'b1;
        br_tgt = 9'h080;
        halt_en = 1'b1;
        halt_pc = 9'h080;
        do_launch(9'h0FD);
        repeat (4) @(negedge clk);
        checks++;
        if (pc !== 9'h080 || busy !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_branch: pc=%h busy=%b ovr=%b want 080 1 0",
                     pc, busy, overrun);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || overrun !== 1'b0 || instr_count !== 16'd4) begin
            errors++;
            $display("FAIL ovr_branch_done: done=%b ovr=%b cnt=%0d want 1 0 4",
                     done, overrun, instr_count);
        end
        br_en = 1'b0;
    endtask

    task automatic test_watchdog;
        w_loop = 1'b1;
        w_halt_en = 1'b0;
        w_do_launch(9'h040);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (w_pc !== 9'h040 || w_busy !== 1'b1 || w_done !== 1'b0) begin
                errors++;
                $display("FAIL wd_run%0d: pc=%h busy=%b done=%b want 040 1 0",
                         i, w_pc, w_busy, w_done);
            end
        end
        @(negedge clk);
        checks++;
        if (w_done !== 1'b1 || w_timeout !== 1'b1 || w_overrun !== 1'b0) begin
            errors++;
            $display("FAIL wd_done: done=%b tmo=%b ovr=%b want 1 1 0",
                     w_done, w_timeout, w_overrun);
        end
        @(negedge clk);
        checks++;
        if (w_done !== 1'b0 || w_timeout !== 1'b1 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_sticky: done=%b tmo=%b busy=%b want 0 1 0",
                     w_done, w_timeout, w_busy);
        end
        w_loop = 1'b0;
        w_halt_en = 1'b1;
        w_halt_pc = 9'h057;
        w_do_launch(9'h050);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (w_pc !== W'(80 + i) || w_fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL wd_halt_run%0d: pc=%h fv=%b want %h 1",
                         i, w_pc, w_fetch_valid, W'(80 + i));
            end
        end
        @(negedge clk);
        checks++;
        if (w_done !== 1'b1 || w_timeout !== 1'b0 || w_instr_count !== 16'd8) begin
            errors++;
            $display("FAIL wd_halt_done: done=%b tmo=%b cnt=%0d want 1 0 8",
                     w_done, w_timeout, w_instr_count);
        end
        w_halt_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        halt_en = 1'b1;
        halt_pc = 9'h011;
        do_launch(9'h010);
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd2) begin
            errors++;
            $display("FAIL b2b_first: done=%b cnt=%0d want 1 2", done, instr_count);
        end
        launch = 1'b1;
        launch_addr = 9'h070;
        halt_pc = 9'h071;
        @(negedge clk);
        launch = 1'b0;
        checks++;
        if (busy !== 1'b1 || pc_start_address !== 9'h070 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_load: busy=%b addr=%h cnt=%0d want 1 070 0",
                     busy, pc_start_address, instr_count);
        end
        @(negedge clk);
        checks++;
        if (pc !== 9'h070 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_run: pc=%h fv=%b want 070 1", pc, fetch_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd2 || pc !== 9'h071) begin
            errors++;
            $display("FAIL b2b_done: done=%b cnt=%0d pc=%h want 1 2 071",
                     done, instr_count, pc);
        end
    endtask

    task automatic test_reset_midrun;
        halt_en = 1'b0;
        br_en = 1'b0;
        do_launch(9'h060);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pc_start !== 1'b1 || pc_start_address !== '0
            || instr_count !== 16'd0 || fetch_valid !== 1'b0 || pc !== '0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b start=%b addr=%h cnt=%0d fv=%b pc=%h",
                     busy, done, pc_start, pc_start_address, instr_count, fetch_valid, pc);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold%0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        rst_n = 1'b1;
        halt_en = 1'b1;
        halt_pc = 9'h032;
        do_launch(9'h030);
        @(negedge clk);
        checks++;
        if (pc !== 9'h030 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL relaunch_run: pc=%h fv=%b want 030 1", pc, fetch_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd3 || pc !== 9'h032) begin
            errors++;
            $display("FAIL relaunch_done: done=%b cnt=%0d pc=%h want 1 3 032",
                     done, instr_count, pc);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall();
        test_branch(1'b1);
        test_branch(1'b0);
        test_overrun();
        test_watchdog();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the program_counter in the emulator core.
- Parks the PC while idle and loads the program start address on launch.
- During run it turns decode results (branch, stall, halt) into the PC's start/branch/taken/target controls.
- Reports completion, instruction count and error status to the testbench/top level.
- The PC has no hold input. A stall is implemented as a taken branch to the current PC.

Parameters:
- INSTR_W, 9: PC/address width.
- SIZE, 256: instruction memory depth; the last valid address is SIZE-1.
- CNT_W, 16: width of the retired-instruction counter and the watchdog counter.
- MAX_CYCLES, 65535: watchdog limit on RUN cycles.

Ports:
- clk  in  1: system clock, rising-edge.
- rst_n  in  1: asynchronous, active-low reset.
- launch  in  1: start-program request; sampled in IDLE/DONE only.
- launch_addr  in  INSTR_W: program start address; captured when launch is accepted.
- pc_value  in  INSTR_W: current PC from program_counter.
- stall  in  1: hold the current instruction this cycle.
- is_branch  in  1: decoded instruction at pc_value is a branch.
- branch_cond  in  1: branch condition true.
- branch_target  in  INSTR_W: branch destination.
- is_halt  in  1: decoded instruction at pc_value is a halt.
- pc_start  out  1: to program_counter start.
- pc_start_address  out  INSTR_W: to program_counter start_address.
- pc_branch  out  1: to program_counter branch.
- pc_taken  out  1: to program_counter taken.
- pc_target  out  INSTR_W: to program_counter target.
- fetch_valid  out  1: the instruction at pc_value is architecturally executed this cycle.
- busy  out  1: state is LOAD or RUN.
- done  out  1: one-cycle pulse on program end.
- timeout  out  1: sticky; the last run ended on the watchdog.
- overrun  out  1: sticky; the last run fell off the end of memory.
- instr_count  out  CNT_W: instructions retired in the current/last run.

Behaviour:
- States: IDLE, LOAD, RUN, DONE. On rst_n low, asynchronously:
  - state=IDLE, addr_reg=0, instr_count=0, cycle_cnt=0, timeout=0, overrun=0.
  - All PC control outputs follow IDLE decode.
- All PC control outputs are combinational from state, registers and inputs. Status outputs are registered.
- IDLE:
  - Outputs: pc_start=1, pc_start_address=addr_reg, so the PC stays parked; fetch_valid=0, busy=0.
  - launch=1: capture addr_reg<=launch_addr; clear instr_count, cycle_cnt, timeout, overrun; go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: pc_start=1, pc_start_address=addr_reg.
  - Always go to RUN. pc_value equals addr_reg on the first RUN cycle.
- RUN: pc_start=0, busy=1. Priority per cycle, highest first:
  1. stall=1:
     - pc_branch=1, pc_taken=1, pc_target=pc_value; fetch_valid=0.
     - The decode inputs are ignored.
  2. is_halt=1:
     - fetch_valid=1; instr_count+1.
     - pc_branch=1, pc_taken=1, pc_target=pc_value, so the PC freezes on the halt.
     - Go to DONE.
  3. is_branch=1:
     - fetch_valid=1; pc_branch=1, pc_taken=branch_cond, pc_target=branch_target.
  4. Otherwise: fetch_valid=1; branch=0, taken=0.
- Overrun:
  - Condition: in RUN, a fetch_valid cycle where pc_value==SIZE-1, and the cycle is not a halt and not a taken branch.
  - Action: set overrun=1; pc_target=pc_value with branch=taken=1; go to DONE.
  - The instruction still retires.
- Watchdog:
  - cycle_cnt increments every RUN cycle, stalls included.
  - When cycle_cnt==MAX_CYCLES-1 and the cycle is not already a halt/overrun exit: set timeout=1, freeze the PC as for a stall, go to DONE.
  - A halt or overrun in the same cycle wins; timeout stays 0.
- DONE (1 cycle):
  - done=1; PC controls as in IDLE.
  - launch=1 is accepted as in IDLE (back-to-back runs), otherwise go to IDLE.
- instr_count saturates at all-ones and holds until the next accepted launch.
- launch during LOAD/RUN is ignored.
- rst_n asserted mid-run aborts immediately to IDLE; no done pulse.

Test Plan:
- Launch at 0x010, no branches, halt decoded when pc_value=0x014:
  - LOAD 1 cycle, RUN pc 0x010..0x014.
  - done pulses the cycle after the halt; instr_count=5; PC holds 0x014.
- Launch 0x000, stall high for 3 cycles at pc=0x002:
  - pc_value stays 0x002 for those 3 cycles with fetch_valid=0.
  - Resumes at 0x003; halt at 0x005 gives instr_count=6.
- Branch at 0x004: cond=1, target 0x020 gives next pc 0x020. Repeat with cond=0 gives next pc 0x005. Both: instr_count increments once.
- Launch 0x0FD, SIZE=256, no halt:
  - Retires 0x0FD, 0x0FE, 0x0FF; overrun=1, done pulse, instr_count=3.
  - A taken branch at 0x0FF instead: no overrun.
- MAX_CYCLES=8, tight loop (branch to self):
  - timeout=1 and done after 8 RUN cycles.
  - A halt on cycle 8: timeout=0.
- rst_n low mid-RUN: outputs reset asynchronously before the next clk edge; busy=0, no done. Relaunch at 0x030 works normally.
